// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-stage accesses onto one shared single-port memory.
// Build macro ARB_FAIR_EN adds a starvation counter that bounds how long fetch waits.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_fetch,
    output logic              stall_mem
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateType;
    typedef enum logic {OWN_IF, OWN_DM} ownerType;

    if (MEM_LAT < 1) begin : gBadMemLat
        $error("mem_port_arbiter: MEM_LAT must be at least 1");
    end
    if (STARVE_MAX < 1) begin : gBadStarveMax
        $error("mem_port_arbiter: STARVE_MAX must be at least 1");
    end

    stateType          state;
    stateType          stateNext;
    ownerType          owner;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addrQ;
    logic              weQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] ifRdataQ;
    logic [DATA_W-1:0] dmRdataQ;
    logic              grantIf;
    logic              grantDm;
    logic              lastBeat;
    logic              ifFavoured;

    assign lastBeat = (cnt == '0);

`ifdef ARB_FAIR_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    // Counts data grants won while fetch was also waiting; saturates at STARVE_MAX.
    logic [STARVE_W-1:0] starveCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            starveCnt <= '0;
        end else if (grantIf || (grantDm && !if_req)) begin
            starveCnt <= '0;
        end else if (grantDm && (starveCnt != STARVE_W'(STARVE_MAX))) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end

    assign ifFavoured = if_req && (starveCnt == STARVE_W'(STARVE_MAX));
`else
    assign ifFavoured = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        stateNext = state;
        grantIf   = 1'b0;
        grantDm   = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req && !ifFavoured) begin
                    grantDm   = 1'b1;
                    stateNext = BUSY;
                end else if (if_req) begin
                    grantIf   = 1'b1;
                    stateNext = BUSY;
                end
            end
            BUSY:    if (lastBeat) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: reset is synchronous and active-high, so it is only checked inside the clocked block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= OWN_IF;
            cnt      <= '0;
            addrQ    <= '0;
            weQ      <= 1'b0;
            wdataQ   <= '0;
            ifRdataQ <= '0;
            dmRdataQ <= '0;
        end else if (grantDm || grantIf) begin
            owner  <= grantDm ? OWN_DM : OWN_IF;
            addrQ  <= grantDm ? dm_addr : if_addr;
            weQ    <= grantDm && dm_we;
            wdataQ <= grantDm ? dm_wdata : '0;
            cnt    <= CNT_W'(MEM_LAT - 1);
        end else if (state == BUSY) begin
            if (!lastBeat) begin
                cnt <= cnt - 1'b1;
            end else if (!weQ) begin
                // Memory read data is only valid in the final BUSY cycle.
                if (owner == OWN_DM) dmRdataQ <= mem_rdata;
                else                 ifRdataQ <= mem_rdata;
            end
        end
    end

    assign mem_en      = (state == BUSY);
    assign mem_we      = (state == BUSY) && weQ;
    assign mem_addr    = (state == BUSY) ? addrQ  : '0;
    assign mem_wdata   = (state == BUSY) ? wdataQ : '0;

    assign if_ready    = (state == DONE) && (owner == OWN_IF);
    assign dm_ready    = (state == DONE) && (owner == OWN_DM);
    assign if_rdata    = ifRdataQ;
    assign dm_rdata    = dmRdataQ;

    assign stall_fetch = if_req && !if_ready;
    assign stall_mem   = dm_req && !dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4); memory data is a bench-driven value.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        stall_fetch;
    logic        stall_mem;
    logic [15:0] memData;

    int compared   = 0;
    int mismatched = 0;

    assign mem_rdata = memData;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_fetch(stall_fetch), .stall_mem(stall_mem)
    );

    // Control outputs packed as {mem_en, mem_we, if_ready, dm_ready, stall_fetch, stall_mem}.
    function automatic logic [5:0] ctrlVec();
        return {mem_en, mem_we, if_ready, dm_ready, stall_fetch, stall_mem};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; memData = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if (ctrlVec() !== 6'b000000) begin
            mismatched++; $display("FAIL reset_ctrl: got %b expected %b", ctrlVec(), 6'b000000);
        end
        compared++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 64'h0) begin
            mismatched++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        if_req = 1'b1;
        #1;
        compared++;
        if (stall_fetch !== 1'b1) begin
            mismatched++; $display("FAIL reset_stall_fetch: got %b expected 1", stall_fetch);
        end
        if_req = 1'b0;
        reset  = 1'b0;
    endtask

    task automatic test_fetch_only();
        logic [5:0] expVec [4] = '{6'b000010, 6'b100010, 6'b100010, 6'b001000};
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0010; memData = 16'hDEAD;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            compared++;
            if (ctrlVec() !== expVec[c]) begin
                mismatched++; $display("FAIL fetch_ctrl c%0d: got %b expected %b", c, ctrlVec(), expVec[c]);
            end
            if (c == 1 || c == 2) begin
                compared++;
                if (mem_addr !== 16'h0010) begin
                    mismatched++; $display("FAIL fetch_addr c%0d: got %h expected 0010", c, mem_addr);
                end
            end
            if (c == 1) begin
                memData = 16'hA5A5;
                if_addr = 16'h9999;
            end
            if (c == 3) begin
                compared++;
                if (if_rdata !== 16'hA5A5) begin
                    mismatched++; $display("FAIL fetch_rdata: got %h expected a5a5", if_rdata);
                end
                if_req = 1'b0;
            end
        end
        @(negedge clk);
        compared++;
        if (ctrlVec() !== 6'b000000) begin
            mismatched++; $display("FAIL fetch_idle: got %b expected 000000", ctrlVec());
        end
    endtask

    task automatic test_data_write();
        logic [5:0] expVec [4] = '{6'b000001, 6'b110001, 6'b110001, 6'b000100};
        bit seen = 1'b0;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0100; memData = 16'h5A5A;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            if (dm_ready) seen = 1'b1;
        end
        compared++;
        if (!seen || dm_rdata !== 16'h5A5A) begin
            mismatched++; $display("FAIL seed_read: ready %b rdata %h expected ready 1 rdata 5a5a", seen, dm_rdata);
        end
        dm_req = 1'b0;

        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234; memData = 16'hFFFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            compared++;
            if (ctrlVec() !== expVec[c]) begin
                mismatched++; $display("FAIL write_ctrl c%0d: got %b expected %b", c, ctrlVec(), expVec[c]);
            end
            if (c == 1 || c == 2) begin
                compared++;
                if ({mem_addr, mem_wdata} !== {16'h0200, 16'h1234}) begin
                    mismatched++;
                    $display("FAIL write_bus c%0d: got %h/%h expected 0200/1234", c, mem_addr, mem_wdata);
                end
            end
            if (c == 1) begin
                dm_addr  = 16'h0BAD;
                dm_wdata = 16'hBEEF;
            end
            if (c == 3) begin
                compared++;
                if (dm_rdata !== 16'h5A5A) begin
                    mismatched++; $display("FAIL write_rdata_hold: got %h expected 5a5a", dm_rdata);
                end
                dm_req = 1'b0; dm_we = 1'b0;
            end
        end
    endtask

    task automatic test_collision();
        logic [5:0] expVec [8] = '{6'b000011, 6'b110011, 6'b110011, 6'b000110,
                                   6'b000010, 6'b100010, 6'b100010, 6'b001000};
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0020;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0300; dm_wdata = 16'hBEEF;
        memData = 16'h2222;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            compared++;
            if (ctrlVec() !== expVec[c]) begin
                mismatched++; $display("FAIL collide_ctrl c%0d: got %b expected %b", c, ctrlVec(), expVec[c]);
            end
            if (c == 1 || c == 5) begin
                compared++;
                if (mem_addr !== ((c == 1) ? 16'h0300 : 16'h0020)) begin
                    mismatched++; $display("FAIL collide_addr c%0d: got %h expected %h",
                                           c, mem_addr, (c == 1) ? 16'h0300 : 16'h0020);
                end
            end
            if (c == 3) dm_req = 1'b0;
            if (c == 7) begin
                compared++;
                if ({if_rdata, dm_rdata} !== {16'h2222, 16'h5A5A}) begin
                    mismatched++;
                    $display("FAIL collide_rdata: got %h/%h expected 2222/5a5a", if_rdata, dm_rdata);
                end
                if_req = 1'b0; dm_we = 1'b0;
            end
        end
    endtask

    task automatic test_fairness();
        logic [6:0] order   = '0;
        logic [6:0] expOrder;
        int         grants  = 0;
        int         dmDone  = 0;
        bit         both    = 1'b0;
`ifdef ARB_FAIR_EN
        expOrder = 7'b0010000;
`else
        expOrder = 7'b1000000;
`endif
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0040;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0400; memData = 16'h3333;
        for (int cyc = 0; cyc < 80 && grants < 7; cyc++) begin
            @(negedge clk);
            if (if_ready && dm_ready) both = 1'b1;
            if (if_ready) begin
                order[grants] = 1'b1;
                grants++;
                if_req = 1'b0;
            end
            if (dm_ready) begin
                order[grants] = 1'b0;
                grants++;
                dmDone++;
                if (dmDone == 6) dm_req = 1'b0;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        compared++;
        if (grants !== 7) begin
            mismatched++; $display("FAIL fair_grant_count: got %0d expected 7", grants);
        end
        compared++;
        if (both !== 1'b0) begin
            mismatched++; $display("FAIL fair_dual_ready: got %b expected 0", both);
        end
        for (int i = 0; i < 7; i++) begin
            compared++;
            if (order[i] !== expOrder[i]) begin
                mismatched++; $display("FAIL fair_order g%0d: got %s expected %s", i,
                                       order[i] ? "IF" : "DM", expOrder[i] ? "IF" : "DM");
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0500; memData = 16'h7777;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (mem_en !== 1'b1) begin
            mismatched++; $display("FAIL rst_busy1: got mem_en %b expected 1", mem_en);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (ctrlVec() !== 6'b000001) begin
            mismatched++; $display("FAIL rst_abort_ctrl: got %b expected 000001", ctrlVec());
        end
        compared++;
        if ({if_rdata, dm_rdata} !== 32'h0) begin
            mismatched++; $display("FAIL rst_abort_rdata: got %h/%h expected 0000/0000", if_rdata, dm_rdata);
        end
        dm_req = 1'b0;
        reset  = 1'b0;
        for (int c = 4; c < 6; c++) begin
            @(negedge clk);
            compared++;
            if (ctrlVec() !== 6'b000000) begin
                mismatched++; $display("FAIL rst_after c%0d: got %b expected 000000", c, ctrlVec());
            end
        end
    endtask

    task automatic test_req_drop();
        int pulses = 0;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0600; memData = 16'h4321;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (mem_en !== 1'b1) begin
            mismatched++; $display("FAIL drop_busy1: got mem_en %b expected 1", mem_en);
        end
        dm_req = 1'b0;
        for (int c = 2; c < 7; c++) begin
            @(negedge clk);
            if (dm_ready) pulses++;
            if (c == 3) begin
                compared++;
                if (ctrlVec() !== 6'b000100 || dm_rdata !== 16'h4321) begin
                    mismatched++; $display("FAIL drop_done: got %b/%h expected 000100/4321", ctrlVec(), dm_rdata);
                end
            end
        end
        compared++;
        if (pulses !== 1) begin
            mismatched++; $display("FAIL drop_pulses: got %0d expected 1", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_data_write();
        test_collision();
        test_fairness();
        test_reset_mid_access();
        test_req_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer for one shared single-port memory used by both the fetch stage (instruction reads) and the memory stage (data reads and writes). The block arbitrates between the two stages, runs each access for a fixed number of cycles, and returns a one-cycle completion pulse with read data. While a stage waits, the block asserts a stall toward the pipeline so that stage's state and buffers hold. It sits between the Fetch/MemoryStage blocks and the memory macro, in the `clk` domain.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 2, cycles `mem_en` is held per access (≥1)
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (used only with ARB_FAIR_EN)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held until `if_ready` is sampled
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  instruction read data; holds its last completed value
- if_ready  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request; held until `dm_ready` is sampled
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  data read result; holds its last completed value
- dm_ready  out  1  one-cycle data completion pulse
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the last BUSY cycle
- stall_fetch  out  1  `if_req` high and `if_ready` low
- stall_mem  out  1  `dm_req` high and `dm_ready` low

## Operation
- States: IDLE, BUSY, DONE. Owner register: IF or DM.
- IDLE, arbitration:
  - `dm_req` wins over `if_req` (strict priority; see Configuration).
  - On a grant, latch the owner, address, `we` and `wdata`, load `cnt = MEM_LAT-1`, then go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - Drive `mem_en=1` and `mem_addr`, `mem_we`, `mem_wdata` from the latches. Stage inputs are not passed through.
  - `mem_we` is 0 for all IF grants.
  - When `cnt==0`: on a read, capture `mem_rdata` into the owner's rdata register; go to DONE. Otherwise decrement `cnt`.
- DONE:
  - Pulse the owner's ready for this cycle only, then go to IDLE.
  - A DM write pulses `dm_ready`; `dm_rdata` is unchanged.
- Requester rule: on the edge where ready is sampled high, the requester must drop req or present a new request. A request still high in IDLE is treated as new.
- Req dropped mid-access: the access still completes and the ready pulse is still issued.
- Changes to address or data inputs after the grant are ignored.
- Reset: `if_rdata`, `dm_rdata` and `cnt` = 0, state = IDLE, owner = IF, starvation counter = 0.
  - All outputs are 0 after reset. `stall_*` follow their combinational definition.
  - Reset during BUSY or DONE aborts the access: `mem_en` is low on the next cycle and no ready pulse is issued.

## Timing
- Request seen in IDLE at cycle 0: `mem_en` is high on cycles 1..MEM_LAT and ready pulses on cycle MEM_LAT+1.
- Minimum spacing between grants: MEM_LAT+2 cycles.
- `stall_*` is combinational from req and ready, so it drops in the same cycle ready pulses.
- A losing requester's stall stays high through the winner's entire access.
- `if_ready` and `dm_ready` are never high in the same cycle.

## Configuration
- ARB_FAIR_EN defined:
  - A saturating counter counts DM grants made while `if_req` is high. It clears on any IF grant, or on a DM grant while `if_req` is low.
  - When the counter reaches STARVE_MAX and both requests are high, IF wins.
- ARB_FAIR_EN undefined: strict DM priority; the counter is not built.

## Test plan
- Fetch only, MEM_LAT=2: `if_req=1`, `if_addr=0x0010`, memory returns 0xA5A5 → `mem_en` is high for 2 cycles, `if_ready` pulses at cycle 3, `if_rdata=0xA5A5`, `stall_fetch` is high on cycles 0–2.
- Data write: `dm_req=1`, `dm_we=1`, `dm_addr=0x0200`, `dm_wdata=0x1234` → `mem_we=1` with addr 0x0200 / data 0x1234 for 2 cycles, then `dm_ready` pulses; `dm_rdata` is unchanged.
- Collision: both requests raised in the same cycle → DM is served first and `if_ready` pulses at cycle 7 (MEM_LAT=2); `stall_fetch` stays high until then.
- Fairness, ARB_FAIR_EN with STARVE_MAX=4: `dm_req` re-raised immediately for 6 grants while `if_req` is held → the grant order is DM, DM, DM, DM, IF, DM, DM. Without the macro, IF is served only after `dm_req` falls.
- Reset mid-access: assert reset in the 2nd BUSY cycle → no ready pulse, `mem_en=0` the next cycle, and both rdata outputs read 0.
- Req dropped mid-BUSY: `dm_req` falls in the 1st BUSY cycle → the access still completes and `dm_ready` pulses once.
